chnl_fifo_reader: RTL and testbench

- Read-side consumer for one channel FIFO (depth 8, 32-bit words).
- Waits until a full packet's worth of words is buffered, then requests the downstream formatter/arbiter.
- After grant, drains exactly one packet of words through a valid/ready interface, flagging the first and last words.
- Sits between the channel FIFO read port and the formatter.

---
 rtl/chnl_fifo_reader_if.sv | 48 ++++
 rtl/chnl_fifo_reader.sv | 128 ++++++++++++
 tb/tb_chnl_fifo_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chnl_fifo_reader_if.sv
// Channel FIFO reader bundle: FIFO read port, formatter request/grant and
// the valid/ready word stream, plus the channel control inputs.
// The reader is the master; the FIFO and formatter side is the slave.
interface chnl_fifo_reader_if #(
  parameter int FIFO_WIDE     = 32,
  parameter int FIFO_PTR_WIDE = 3
);
  // channel control
  logic                     chnl_en;
  logic [1:0]               pkt_len_sel;

  // FIFO read port
  logic                     fifo_empty;
  logic [FIFO_PTR_WIDE:0]   fifo_slack;
  logic [FIFO_WIDE-1:0]     fifo_data_out;
  logic                     fifo_rd_en;

  // formatter request / grant
  logic                     fmt_req;
  logic                     fmt_grant;

  // formatter word stream
  logic                     fmt_valid;
  logic                     fmt_ready;
  logic [FIFO_WIDE-1:0]     fmt_data;
  logic                     fmt_start;
  logic                     fmt_end;

  modport master (
    input  chnl_en, pkt_len_sel,
    input  fifo_empty, fifo_slack, fifo_data_out,
    output fifo_rd_en,
    output fmt_req,
    input  fmt_grant,
    output fmt_valid, fmt_data, fmt_start, fmt_end,
    input  fmt_ready
  );

  modport slave (
    output chnl_en, pkt_len_sel,
    output fifo_empty, fifo_slack, fifo_data_out,
    input  fifo_rd_en,
    input  fmt_req,
    output fmt_grant,
    input  fmt_valid, fmt_data, fmt_start, fmt_end,
    output fmt_ready
  );
endinterface

// File: rtl/chnl_fifo_reader.sv
// Read-side consumer for one channel FIFO. Waits until a whole packet is
// buffered, requests the formatter, and after the grant drains exactly one
// packet through a valid/ready stream with first/last word markers.
// fmt_data is taken straight from the FIFO read data register, so a word is
// presented the cycle after its read strobe and held until the next read.
module chnl_fifo_reader #(
  parameter int FIFO_DEPTH    = 8,
  parameter int FIFO_WIDE     = 32,
  parameter int FIFO_PTR_WIDE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  chnl_fifo_reader_if.master  bus
);

  localparam int CW = FIFO_PTR_WIDE + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t          state_reg,   state_next;
  logic [CW-1:0]   plen_reg,    plen_next;
  logic [CW-1:0]   rd_left_reg, rd_left_next;
  logic            pend_reg,    pend_next;
  logic            start_reg,   start_next;
  logic            end_reg,     end_next;

  logic [CW-1:0]   occ;
  logic [CW-1:0]   plen_dec;
  logic            rd_en;
  logic            word_xfer;

  // Buffered word count and the packet length selected by the current code.
  assign occ      = DEPTH_C - bus.fifo_slack;
  assign plen_dec = CW'(1) << bus.pkt_len_sel;

  // A word leaves the block whenever a presented word meets ready.
  assign word_xfer = pend_reg & bus.fmt_ready;

  // State register and per-packet bookkeeping; reset aborts any packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      plen_reg    <= '0;
      rd_left_reg <= '0;
      pend_reg    <= 1'b0;
      start_reg   <= 1'b0;
      end_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      plen_reg    <= plen_next;
      rd_left_reg <= rd_left_next;
      pend_reg    <= pend_next;
      start_reg   <= start_next;
      end_reg     <= end_next;
    end
  end

  // Next-state, read issue and word tagging.
  always_comb begin
    state_next   = state_reg;
    plen_next    = plen_reg;
    rd_left_next = rd_left_reg;
    start_next   = start_reg;
    end_next     = end_reg;
    rd_en        = 1'b0;

    case (state_reg)
      IDLE: begin
        // Length is frozen here so a later pkt_len_sel change cannot
        // disturb the packet in flight.
        if (bus.chnl_en && (occ >= plen_dec)) begin
          state_next = REQ;
          plen_next  = plen_dec;
        end
      end

      REQ: begin
        // A grant arriving together with chnl_en falling is honoured: the
        // formatter has already committed its slot to this channel.
        if (bus.fmt_grant) begin
          state_next   = SEND;
          rd_left_next = plen_reg;
        end else if (!bus.chnl_en) begin
          state_next = IDLE;
        end
      end

      SEND: begin
        // Read only when a word is still owed, the FIFO has data, and the
        // output slot is free or being emptied this cycle. An empty FIFO
        // here just stalls until data shows up.
        rd_en = (rd_left_reg != '0) & ~bus.fifo_empty & (~pend_reg | bus.fmt_ready);
        if (rd_en) begin
          rd_left_next = rd_left_reg - CW'(1);
          start_next   = (rd_left_reg == plen_reg);
          end_next     = (rd_left_reg == CW'(1));
        end
        // The last word was read when rd_left hit zero, so no read can be
        // racing this exit.
        if (word_xfer && end_reg) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Output slot stays occupied until the formatter takes the word.
    pend_next = rd_en | (pend_reg & ~bus.fmt_ready);
  end

  // Outputs: request is a decode of the state register, markers are only
  // meaningful while a word is presented.
  assign bus.fifo_rd_en = rd_en;
  assign bus.fmt_req    = (state_reg == REQ);
  assign bus.fmt_valid  = pend_reg;
  assign bus.fmt_data   = bus.fifo_data_out;
  assign bus.fmt_start  = pend_reg & start_reg;
  assign bus.fmt_end    = pend_reg & end_reg;

endmodule

// File: tb/tb_chnl_fifo_reader.sv
// Bench for chnl_fifo_reader: a small behavioural FIFO feeds the reader,
// directed stimulus pushes expected words into a scoreboard queue, and a
// negedge monitor pops and compares every transferred word.
module tb_chnl_fifo_reader;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  chnl_fifo_reader_if #(.FIFO_WIDE(32), .FIFO_PTR_WIDE(3)) bus ();

  chnl_fifo_reader #(
    .FIFO_DEPTH(8), .FIFO_WIDE(32), .FIFO_PTR_WIDE(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rd_pulses = 0;

  // ---------------- behavioural channel FIFO ----------------
  logic [31:0] mem [8];
  logic [2:0]  wp = '0;
  logic [2:0]  rp = '0;
  int          cnt = 0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ok, rd_ok;
  logic [31:0] fifo_q = '0;

  assign wr_ok = wr_en && (cnt < 8);
  assign rd_ok = bus.fifo_rd_en && (cnt > 0);
  assign bus.fifo_empty    = (cnt == 0);
  assign bus.fifo_slack    = 4'(8 - cnt);
  assign bus.fifo_data_out = fifo_q;

  always @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= wr_data;
      wp <= wp + 3'd1;
    end
    if (rd_ok) begin
      fifo_q <= mem[rp];
      rp <= rp + 3'd1;
    end
    cnt <= cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } exp_t;
  exp_t sb[$];

  logic        stall_prev = 1'b0;
  logic [31:0] held_d;
  logic        held_s, held_e;

  // Monitor: read strobe legality, stall stability, and word comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        rd_pulses++;
        n_checks++;
        if (bus.fifo_empty) begin
          n_fail++;
          $display("FAIL rd_while_empty: fifo_rd_en=1 fifo_empty=1 required fifo_rd_en=0");
        end
      end
      if (stall_prev) begin
        n_checks++;
        if (!bus.fmt_valid || bus.fmt_data !== held_d ||
            bus.fmt_start !== held_s || bus.fmt_end !== held_e) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%0b data=%0d start=%0b end=%0b required valid=1 data=%0d start=%0b end=%0b",
                   bus.fmt_valid, bus.fmt_data, bus.fmt_start, bus.fmt_end, held_d, held_s, held_e);
        end
      end
      if (bus.fmt_valid && !bus.fmt_ready) begin
        n_checks++;
        if (bus.fifo_rd_en) begin
          n_fail++;
          $display("FAIL rd_in_stall: fifo_rd_en=1 required 0 while fmt_ready=0");
        end
      end
      if (bus.fmt_valid && bus.fmt_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: data=%0d start=%0b end=%0b required no word",
                   bus.fmt_data, bus.fmt_start, bus.fmt_end);
        end else begin
          exp_t x;
          x = sb.pop_front();
          if (bus.fmt_data !== x.d || bus.fmt_start !== x.s || bus.fmt_end !== x.e) begin
            n_fail++;
            $display("FAIL word: data=%0d start=%0b end=%0b required data=%0d start=%0b end=%0b",
                     bus.fmt_data, bus.fmt_start, bus.fmt_end, x.d, x.s, x.e);
          end else begin
            $display("word data=%0d start=%0b end=%0b ok", bus.fmt_data, bus.fmt_start, bus.fmt_end);
          end
        end
      end
      stall_prev = bus.fmt_valid && !bus.fmt_ready;
      held_d = bus.fmt_data;
      held_s = bus.fmt_start;
      held_e = bus.fmt_end;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_word(logic [31:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push_exp(logic [31:0] d, logic s, logic e);
    exp_t x;
    x.d = d;
    x.s = s;
    x.e = e;
    sb.push_back(x);
  endtask

  // Wait (bounded) for the request, then pulse grant for one cycle.
  // Returns one time unit after the edge that sampled the grant.
  task automatic wait_req_grant();
    for (int i = 0; i < 20 && !bus.fmt_req; i++) tick();
    check("req_seen", bus.fmt_req, 1);
    bus.fmt_grant = 1'b1;
    tick();
    bus.fmt_grant = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || bus.fmt_valid); i++) tick();
    check("drain_done", (sb.size() == 0 && !bus.fmt_valid) ? 1 : 0, 1);
  endtask

  // Grant, then check the read/data latency and a gap-free n-word burst.
  task automatic grant_and_stream(int n);
    wait_req_grant();
    check("req_drop", bus.fmt_req, 0);
    check("rd_en_after_grant", bus.fifo_rd_en, 1);
    check("no_valid_rd_cycle", bus.fmt_valid, 0);
    tick();
    for (int k = 0; k < n; k++) begin
      check("valid_continuous", bus.fmt_valid, 1);
      tick();
    end
    check("valid_after_pkt", bus.fmt_valid, 0);
    check("rd_pulse_count", rd_pulses, n);
    check("queue_empty", sb.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit req_seen;
    rst_n           = 1'b0;
    bus.chnl_en     = 1'b0;
    bus.pkt_len_sel = 2'd0;
    bus.fmt_grant   = 1'b0;
    bus.fmt_ready   = 1'b1;

    // Reset values and idle behaviour with an empty FIFO.
    tick(); tick();
    check("rst_req",   bus.fmt_req, 0);
    check("rst_valid", bus.fmt_valid, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_start", bus.fmt_start, 0);
    check("rst_end",   bus.fmt_end, 0);
    rst_n = 1'b1;
    bus.chnl_en = 1'b1;
    tick(); tick(); tick();
    check("idle_empty_req", bus.fmt_req, 0);
    // Grant outside REQ must do nothing.
    bus.fmt_grant = 1'b1;
    tick();
    bus.fmt_grant = 1'b0;
    tick(); tick();
    check("stray_grant_valid", bus.fmt_valid, 0);
    check("stray_grant_rd", rd_pulses, 0);

    // 4-word packet 0..3.
    bus.pkt_len_sel = 2'd2;
    rd_pulses = 0;
    push_exp(0, 1, 0); push_exp(1, 0, 0); push_exp(2, 0, 0); push_exp(3, 0, 1);
    for (int i = 0; i < 4; i++) push_word(i);
    grant_and_stream(4);
    tick(); tick();
    check("idle_after_pkt4", bus.fmt_req, 0);

    // Threshold: 7 buffered words do not satisfy an 8-word packet.
    bus.pkt_len_sel = 2'd3;
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) push_exp(10 + i, (i == 0), (i == 7));
    for (int i = 0; i < 7; i++) push_word(10 + i);
    tick(); tick(); tick();
    check("occ7_no_req", bus.fmt_req, 0);
    push_word(17);
    check("occ8_req_not_yet", bus.fmt_req, 0);
    tick();
    check("occ8_req_within_1", bus.fmt_req, 1);
    grant_and_stream(8);

    // Backpressure on word 0 of a 2-word packet.
    bus.pkt_len_sel = 2'd1;
    rd_pulses = 0;
    push_exp(20, 1, 0); push_exp(21, 0, 1);
    push_word(20); push_word(21);
    bus.fmt_ready = 1'b0;
    wait_req_grant();
    tick();
    check("bp_valid", bus.fmt_valid, 1);
    check("bp_data0", bus.fmt_data, 20);
    check("bp_start0", bus.fmt_start, 1);
    tick(); tick(); tick();
    check("bp_rd_during_stall", rd_pulses, 1);
    bus.fmt_ready = 1'b1;
    drain();
    check("bp_rd_total", rd_pulses, 2);

    // Single-word packet: start and end on the same word.
    bus.pkt_len_sel = 2'd0;
    rd_pulses = 0;
    push_exp(30, 1, 1);
    push_word(30);
    wait_req_grant();
    drain();
    check("plen1_rd", rd_pulses, 1);

    // chnl_en falls mid-packet: packet completes, next request blocked.
    bus.pkt_len_sel = 2'd3;
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) push_exp(40 + i, (i == 0), (i == 7));
    for (int i = 0; i < 8; i++) push_word(40 + i);
    wait_req_grant();
    tick();
    bus.chnl_en = 1'b0;
    drain();
    check("chnl_off_rd", rd_pulses, 8);
    bus.pkt_len_sel = 2'd0;
    push_word(50);
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fmt_req) req_seen = 1'b1;
    end
    check("chnl_off_no_req", req_seen, 0);
    bus.chnl_en = 1'b1;
    push_exp(50, 1, 1);
    wait_req_grant();
    drain();

    // Reset mid-packet after word 0 transferred and word 1 presented.
    bus.pkt_len_sel = 2'd2;
    push_exp(0, 1, 0);
    for (int i = 0; i < 4; i++) push_word(i);
    wait_req_grant();
    tick();
    tick();
    bus.fmt_ready = 1'b0;
    check("pre_rst_valid", bus.fmt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.fmt_valid, 0);
    check("async_rst_req",   bus.fmt_req, 0);
    check("async_rst_rd",    bus.fifo_rd_en, 0);
    check("async_rst_start", bus.fmt_start, 0);
    check("async_rst_end",   bus.fmt_end, 0);
    tick(); tick();
    rst_n = 1'b1;
    bus.fmt_ready = 1'b1;
    rd_pulses = 0;
    push_exp(2, 1, 0); push_exp(3, 0, 0); push_exp(4, 0, 0); push_exp(5, 0, 1);
    push_word(4); push_word(5);
    wait_req_grant();
    drain();
    check("post_rst_rd", rd_pulses, 4);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
